sa_w_order_sched: RTL and testbench
===================================

SA_W_ORDER_SCHED -- requirements
Module: sa_w_order_sched

Interface
REQ-001 The block SHALL have parameter MST_AMT, default 2, giving the number of masters sharing one slave W channel.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the WDATA width.
REQ-003 The block SHALL have parameter ORD_DEPTH, default 4, giving the order FIFO depth (power of 2, at least 2).
REQ-004 The block SHALL have parameter MST_ID_W, default $clog2(MST_AMT), giving the master index width.
REQ-005 The block SHALL have port ACLK_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port ARESET_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port aw_grant_valid_i, input, 1 bit: the AW arbiter granted a write address to this slave.
REQ-008 The block SHALL have port aw_grant_mst_id_i, input, MST_ID_W bits: the index of the granted master.
REQ-009 The block SHALL have port aw_grant_ready_o, output, 1 bit: the order FIFO can accept a grant.
REQ-010 The block SHALL have port m_WDATA_i, input, DATA_WIDTH*MST_AMT bits: per-master WDATA, master i in slice [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
REQ-011 The block SHALL have port m_WLAST_i, input, MST_AMT bits: per-master WLAST.
REQ-012 The block SHALL have port m_WVALID_i, input, MST_AMT bits: per-master WVALID.
REQ-013 The block SHALL have port m_WREADY_o, output, MST_AMT bits: per-master WREADY.
REQ-014 The block SHALL have port s_WDATA_o, output, DATA_WIDTH bits: WDATA toward the slave.
REQ-015 The block SHALL have port s_WLAST_o, output, 1 bit: WLAST toward the slave.
REQ-016 The block SHALL have port s_WVALID_o, output, 1 bit: WVALID toward the slave.
REQ-017 The block SHALL have port s_WREADY_i, input, 1 bit: WREADY from the slave.
REQ-018 The block SHALL have port ord_cnt_o, output, $clog2(ORD_DEPTH)+1 bits: the number of queued grants.
REQ-019 The block SHALL have port beat_cnt_o, output, 8 bits: beats accepted in the current burst, saturating at 255.

Function
REQ-020 Push: the block SHALL write aw_grant_mst_id_i into the order FIFO when aw_grant_valid_i and aw_grant_ready_o are both high.
REQ-021 aw_grant_ready_o SHALL equal ~full & ~ARESET_i, with no pop-bypass when full.
REQ-022 The head entry SHALL select the active master; a burst SHALL NOT be forwarded in the cycle its grant is pushed into an empty FIFO (1-cycle latency minimum).
REQ-023 Data path, combinational: s_WVALID_o = ~empty & m_WVALID_i[head]; s_WDATA_o and s_WLAST_o = the head master's slice; these outputs are 0 when empty.
REQ-024 m_WREADY_o[i] SHALL equal ~empty & (head==i) & s_WREADY_i; every non-head bit SHALL be 0.
REQ-025 Pop: the block SHALL pop the head when s_WVALID_o & s_WREADY_i & s_WLAST_o; the next burst is eligible in the following cycle.
REQ-026 When a push and a pop occur in the same cycle, ord_cnt_o SHALL be unchanged and both pointers SHALL advance.
REQ-027 Read and write pointers SHALL wrap modulo ORD_DEPTH.
REQ-028 full SHALL equal (ord_cnt_o==ORD_DEPTH), and empty SHALL equal (ord_cnt_o==0).
REQ-029 The FSM SHALL have states IDLE (empty) and BURST (head valid).
REQ-030 The FSM SHALL go IDLE->BURST on a push.
REQ-031 The FSM SHALL go BURST->IDLE on a pop with ord_cnt_o==1 and no simultaneous push; otherwise it SHALL stay in BURST.
REQ-032 beat_cnt_o SHALL increment on each slave W handshake, SHALL clear to 0 on the cycle after a WLAST handshake, and SHALL hold at 255.
REQ-033 WVALID from non-head masters SHALL be ignored; it SHALL NOT be lost, and SHALL stay pending at its source.

Reset
REQ-034 While ARESET_i is sampled high, the block SHALL clear the pointers, set ord_cnt_o=0, beat_cnt_o=0 and the FSM to IDLE, and drive aw_grant_ready_o=0, m_WREADY_o=0 and s_WVALID_o=0.
REQ-035 Reset mid-burst SHALL discard all queued grants; the first push after reset SHALL be accepted in the cycle following ARESET_i deassertion.

Structure
REQ-036 The shared interconnect package SHALL hold the FSM state encoding (IDLE/BURST) and the beat-counter width constant (8).
REQ-037 The order FIFO SHALL be one sub-module, sync_fifo_ptr (width MST_ID_W, depth ORD_DEPTH), exposing full, empty and count.

Verification
REQ-038 Scenario: grant M1, then M1 sends a 4-beat burst with s_WREADY_i=1 -> 4 beats on s_W*, WLAST on beat 4, ord_cnt_o goes 1->0, beat_cnt_o goes 1..4 then 0.
REQ-039 Scenario: grants M0 then M1, both WVALID high -> all M0 beats precede M1, and m_WREADY_o[1]=0 until the M0 WLAST handshake.
REQ-040 Scenario: 4 grants with ORD_DEPTH=4 and no W traffic -> aw_grant_ready_o=0 and a 5th grant is not accepted; after one WLAST pop, ready=1 the next cycle.
REQ-041 Scenario: full FIFO, pop and push in the same cycle -> ord_cnt_o stays 4 and the wrap-around order is preserved across 8 bursts.
REQ-042 Scenario: ARESET_i asserted on beat 2 of a burst, with 3 grants queued -> next cycle ord_cnt_o=0, s_WVALID_o=0, and the new grant is accepted the cycle after deassertion.
REQ-043 Scenario: s_WREADY_i toggling 1010 during a 3-beat burst -> s_WDATA_o stable while stalled, and exactly 3 handshakes occur.

Source files
------------

// File: rtl/sa_w_order_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_w_order_sched_pkg
// Brief    : Shared types and constants for the slave-side W order scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sa_w_order_sched_pkg;

    localparam int c_BEAT_CNT_W = 8;
    localparam logic [c_BEAT_CNT_W-1:0] c_BEAT_MAX = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } w_state_t;

endpackage : sa_w_order_sched_pkg
`default_nettype wire

// File: rtl/sa_w_order_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ptr
// Brief    : Synchronous pointer FIFO with occupancy count; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ptr
    import sa_w_order_sched_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo_ptr
`default_nettype wire

// File: rtl/sa_w_order_sched.sv
`default_nettype none
// ============================================================================
// Module   : sa_w_order_sched
// Brief    : Routes W bursts from several masters to one slave in AW-grant order.
// Revision : 1.0 - initial release
// ============================================================================
module sa_w_order_sched
    import sa_w_order_sched_pkg::*;
#(
    parameter int MST_AMT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ORD_DEPTH  = 4,
    parameter int MST_ID_W   = $clog2(MST_AMT)
) (
    input  logic                           ACLK_i,
    input  logic                           ARESET_i,
    input  logic                           aw_grant_valid_i,
    input  logic [MST_ID_W-1:0]            aw_grant_mst_id_i,
    output logic                           aw_grant_ready_o,
    input  logic [DATA_WIDTH*MST_AMT-1:0]  m_WDATA_i,
    input  logic [MST_AMT-1:0]             m_WLAST_i,
    input  logic [MST_AMT-1:0]             m_WVALID_i,
    output logic [MST_AMT-1:0]             m_WREADY_o,
    output logic [DATA_WIDTH-1:0]          s_WDATA_o,
    output logic                           s_WLAST_o,
    output logic                           s_WVALID_o,
    input  logic                           s_WREADY_i,
    output logic [$clog2(ORD_DEPTH):0]     ord_cnt_o,
    output logic [c_BEAT_CNT_W-1:0]        beat_cnt_o
);

    localparam int c_CNT_W = $clog2(ORD_DEPTH) + 1;

    logic                    w_full;
    logic                    w_empty;
    logic [MST_ID_W-1:0]     w_head_id;
    logic [c_CNT_W-1:0]      w_count;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_hs;
    logic                    w_head_valid;
    logic                    w_mst_valid;
    w_state_t                r_state;
    logic [c_BEAT_CNT_W-1:0] r_beat_cnt;
    logic                    r_clr_beat;

    assign aw_grant_ready_o = ~w_full & ~ARESET_i;
    assign w_push           = aw_grant_valid_i & aw_grant_ready_o;
    assign w_head_valid     = (r_state == BURST) & ~w_empty & ~ARESET_i;
    assign s_WVALID_o       = w_mst_valid;
    assign w_hs             = s_WVALID_o & s_WREADY_i;
    assign w_pop            = w_hs & s_WLAST_o;
    assign ord_cnt_o        = w_count;
    assign beat_cnt_o       = r_beat_cnt;

    sync_fifo_ptr #(
        .WIDTH (MST_ID_W),
        .DEPTH (ORD_DEPTH)
    ) u_ord_fifo (
        .clk     (ACLK_i),
        .rst     (ARESET_i),
        .i_push  (w_push),
        .i_data  (aw_grant_mst_id_i),
        .i_pop   (w_pop),
        .o_data  (w_head_id),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Only the head master reaches the slave; others keep their beats pending.
    always_comb begin
        s_WDATA_o   = '0;
        s_WLAST_o   = 1'b0;
        w_mst_valid = 1'b0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (w_head_valid && (w_head_id == MST_ID_W'(i))) begin
                s_WDATA_o   = m_WDATA_i[DATA_WIDTH*i +: DATA_WIDTH];
                s_WLAST_o   = m_WLAST_i[i];
                w_mst_valid = m_WVALID_i[i];
            end
        end
    end

    for (genvar i = 0; i < MST_AMT; i++) begin : g_wready
        assign m_WREADY_o[i] = w_head_valid & (w_head_id == MST_ID_W'(i)) & s_WREADY_i;
    end

    // Beat count of the finished burst stays visible for one cycle before clearing.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_clr_beat <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (w_push) r_state <= BURST;
                BURST:   if (w_pop && !w_push && (w_count == c_CNT_W'(1))) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (r_clr_beat) begin
                r_beat_cnt <= w_hs ? c_BEAT_CNT_W'(1) : '0;
            end else if (w_hs && (r_beat_cnt != c_BEAT_MAX)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            r_clr_beat <= w_pop;
        end
    end

endmodule : sa_w_order_sched
`default_nettype wire

// File: tb/tb_sa_w_order_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_w_order_sched
// Brief    : Self-checking bench; grant-order queue model drives all expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_w_order_sched;

    localparam int MST_AMT    = 2;
    localparam int DATA_WIDTH = 32;
    localparam int ORD_DEPTH  = 4;
    localparam int MST_ID_W   = 1;

    logic                          ACLK_i = 1'b0;
    logic                          ARESET_i;
    logic                          aw_grant_valid_i;
    logic [MST_ID_W-1:0]           aw_grant_mst_id_i;
    logic                          aw_grant_ready_o;
    logic [DATA_WIDTH*MST_AMT-1:0] m_WDATA_i;
    logic [MST_AMT-1:0]            m_WLAST_i;
    logic [MST_AMT-1:0]            m_WVALID_i;
    logic [MST_AMT-1:0]            m_WREADY_o;
    logic [DATA_WIDTH-1:0]         s_WDATA_o;
    logic                          s_WLAST_o;
    logic                          s_WVALID_o;
    logic                          s_WREADY_i;
    logic [$clog2(ORD_DEPTH):0]    ord_cnt_o;
    logic [7:0]                    beat_cnt_o;

    sa_w_order_sched #(
        .MST_AMT    (MST_AMT),
        .DATA_WIDTH (DATA_WIDTH),
        .ORD_DEPTH  (ORD_DEPTH),
        .MST_ID_W   (MST_ID_W)
    ) dut (
        .ACLK_i            (ACLK_i),
        .ARESET_i          (ARESET_i),
        .aw_grant_valid_i  (aw_grant_valid_i),
        .aw_grant_mst_id_i (aw_grant_mst_id_i),
        .aw_grant_ready_o  (aw_grant_ready_o),
        .m_WDATA_i         (m_WDATA_i),
        .m_WLAST_i         (m_WLAST_i),
        .m_WVALID_i        (m_WVALID_i),
        .m_WREADY_o        (m_WREADY_o),
        .s_WDATA_o         (s_WDATA_o),
        .s_WLAST_o         (s_WLAST_o),
        .s_WVALID_o        (s_WVALID_o),
        .s_WREADY_i        (s_WREADY_i),
        .ord_cnt_o         (ord_cnt_o),
        .beat_cnt_o        (beat_cnt_o)
    );

    always #5 ACLK_i = ~ACLK_i;

    // Reference model: grant order queue plus per-master burst sources.
    int          mq[$];
    int          blen[MST_AMT][$];
    int          beat_idx[MST_AMT];
    logic [31:0] cur_data[MST_AMT];
    bit          en[MST_AMT];
    bit          w_allow;
    bit          rand_en;
    int          glen;
    int          exp_beat;
    bit          pend_clr;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < MST_AMT; i++) begin
            m_WVALID_i[i] = w_allow && en[i] && (blen[i].size() > 0);
            m_WLAST_i[i]  = (blen[i].size() > 0) && (beat_idx[i] == blen[i][0] - 1);
            m_WDATA_i[i*DATA_WIDTH +: DATA_WIDTH] = cur_data[i];
        end
    endtask

    task automatic tick();
        int          h;
        bit          hv, hs, lst, psh;
        logic [31:0] ed;
        bit          ev, el;
        logic [MST_AMT-1:0] ewr;
        @(negedge ACLK_i);
        hv  = !ARESET_i && (mq.size() > 0);
        h   = hv ? mq[0] : 0;
        ev  = hv && m_WVALID_i[h];
        ed  = hv ? m_WDATA_i[h*DATA_WIDTH +: DATA_WIDTH] : 32'h0;
        el  = hv && m_WLAST_i[h];
        ewr = '0;
        if (hv && s_WREADY_i) ewr[h] = 1'b1;
        chk("aw_ready", aw_grant_ready_o, (!ARESET_i && mq.size() < ORD_DEPTH));
        chk("s_wvalid", s_WVALID_o, ev);
        chk("s_wdata",  s_WDATA_o, ed);
        chk("s_wlast",  s_WLAST_o, el);
        chk("m_wready", m_WREADY_o, ewr);
        chk("ord_cnt",  ord_cnt_o, mq.size());
        chk("beat_cnt", beat_cnt_o, exp_beat);
        hs  = ev && s_WREADY_i;
        lst = hs && el;
        psh = aw_grant_valid_i && !ARESET_i && (mq.size() < ORD_DEPTH);
        @(posedge ACLK_i);
        if (ARESET_i) begin
            mq.delete();
            exp_beat = 0;
            pend_clr = 1'b0;
            for (int i = 0; i < MST_AMT; i++) begin
                blen[i].delete();
                beat_idx[i] = 0;
            end
        end else begin
            if (pend_clr)                  exp_beat = hs ? 1 : 0;
            else if (hs && exp_beat < 255) exp_beat++;
            pend_clr = lst;
            if (hs) begin
                beat_idx[h]++;
                cur_data[h] = $urandom;
                if (lst) begin
                    void'(blen[h].pop_front());
                    beat_idx[h] = 0;
                    void'(mq.pop_front());
                end
            end
            if (psh) begin
                mq.push_back(int'(aw_grant_mst_id_i));
                blen[aw_grant_mst_id_i].push_back(glen);
            end
        end
        for (int i = 0; i < MST_AMT; i++) begin
            if (!m_WVALID_i[i] || (hs && h == i)) en[i] = rand_en ? ($urandom % 4 != 0) : 1'b1;
        end
        #1;
        drive_masters();
    endtask

    task automatic grant(input int id, input int len);
        aw_grant_valid_i  = 1'b1;
        aw_grant_mst_id_i = MST_ID_W'(id);
        glen              = len;
        tick();
        aw_grant_valid_i  = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((mq.size() > 0 || pend_clr) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_done", mq.size(), 0);
    endtask

    initial begin
        ARESET_i          = 1'b1;
        aw_grant_valid_i  = 1'b0;
        aw_grant_mst_id_i = '0;
        s_WREADY_i        = 1'b0;
        glen              = 1;
        w_allow           = 1'b1;
        rand_en           = 1'b0;
        exp_beat          = 0;
        pend_clr          = 1'b0;
        for (int i = 0; i < MST_AMT; i++) begin
            en[i]       = 1'b1;
            beat_idx[i] = 0;
            cur_data[i] = $urandom;
        end
        m_WVALID_i = '0;
        m_WLAST_i  = '0;
        m_WDATA_i  = '0;
        drive_masters();
        tick();
        tick();
        ARESET_i = 1'b0;
        tick();

        // Single 4-beat burst from M1 with the slave always ready.
        s_WREADY_i = 1'b1;
        grant(1, 4);
        drain(20);
        tick();

        // M0 then M1, both presenting data; M1 must wait for M0's WLAST.
        grant(0, 3);
        grant(1, 2);
        drain(20);

        // Fill the order FIFO with no W traffic, try a fifth grant, then release.
        w_allow = 1'b0;
        drive_masters();
        grant(0, 2);
        grant(1, 1);
        grant(0, 1);
        grant(1, 3);
        grant(0, 2);
        tick();
        w_allow = 1'b1;
        drive_masters();
        drain(60);

        // Full FIFO with push and pop together; order wraps across many bursts.
        w_allow = 1'b0;
        drive_masters();
        for (int k = 0; k < 4; k++) grant(k % 2, 1 + k % 2);
        w_allow = 1'b1;
        drive_masters();
        aw_grant_valid_i = 1'b1;
        for (int k = 0; k < 24; k++) begin
            aw_grant_mst_id_i = MST_ID_W'($urandom % 2);
            glen = 1 + ($urandom % 2);
            tick();
        end
        aw_grant_valid_i = 1'b0;
        drain(80);

        // Reset on beat 2 of a burst with three grants queued.
        w_allow = 1'b0;
        drive_masters();
        grant(0, 4);
        grant(1, 2);
        grant(0, 1);
        w_allow = 1'b1;
        drive_masters();
        tick();
        ARESET_i = 1'b1;
        tick();
        ARESET_i = 1'b0;
        grant(1, 2);
        drain(20);

        // Slave ready toggling during a 3-beat burst.
        s_WREADY_i = 1'b0;
        grant(0, 3);
        for (int k = 0; k < 12 && (mq.size() > 0 || pend_clr); k++) begin
            s_WREADY_i = ~s_WREADY_i;
            tick();
        end
        chk("toggle_drain", mq.size(), 0);

        // Long burst to exercise beat counter saturation.
        s_WREADY_i = 1'b1;
        grant(1, 260);
        drain(300);

        // Randomized traffic with occasional resets.
        rand_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            aw_grant_valid_i  = ($urandom % 3 == 0);
            aw_grant_mst_id_i = MST_ID_W'($urandom % 2);
            glen              = 1 + ($urandom % 4);
            s_WREADY_i        = ($urandom % 4 != 0);
            ARESET_i          = ($urandom % 150 == 0);
            tick();
        end
        ARESET_i         = 1'b0;
        aw_grant_valid_i = 1'b0;
        rand_en          = 1'b0;
        s_WREADY_i       = 1'b1;
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sa_w_order_sched
`default_nettype wire
